// File: rtl/mips_boot_pkg.sv
// mips_boot_pkg: shared state encoding and byte-lane helper for the MIPS boot controller
package mips_boot_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_I, S_LOAD_D, S_RUN, S_DRAIN, S_DONE, S_ERROR, S_TIMEOUT
    } state_t;
    localparam int BYTES_PER_WORD = 4;
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
        return word[8*idx +: 8];
    endfunction
endpackage

// File: rtl/mips_word_serializer.sv
// mips_word_serializer: accepts one word plus base address and emits four little-endian byte writes
module mips_word_serializer
    import mips_boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    input  logic [31:0] in_base,
    input  logic        in_last,
    output logic        wr_en_d,
    output logic [31:0] wr_addr_d,
    output logic [7:0]  wr_data_d,
    output logic        word_done,
    output logic        cur_last,
    output logic [31:0] cur_base
);
    logic [31:0] word_q, word_d, base_q, base_d;
    logic        last_q, last_d, act_q, act_d, acc;
    logic [1:0]  idx_q, idx_d;
    // wr_*_d describe the byte the owner registers for the next cycle
    always_comb begin
        in_ready  = !act_q || (idx_q == 2'd3 && !last_q);
        word_done = act_q && idx_q == 2'd3;
        acc       = in_valid && in_ready;
        word_d    = acc ? in_word : word_q;
        base_d    = acc ? in_base : base_q;
        last_d    = acc ? in_last : last_q;
        act_d     = acc || (act_q && idx_q != 2'd3);
        idx_d     = acc ? 2'd0 : idx_q + 2'd1;
        wr_en_d   = act_d;
        wr_addr_d = base_d + {30'd0, idx_d};
        wr_data_d = byte_lane(word_d, idx_d);
        cur_last  = last_q;
        cur_base  = base_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            base_q <= '0;
            last_q <= 1'b0;
            act_q  <= 1'b0;
            idx_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            base_q <= base_d;
            last_q <= last_d;
            act_q  <= act_d;
            idx_q  <= idx_d;
        end
    end
endmodule

// File: rtl/mips_boot_ctrl.sv
// mips_boot_ctrl: loads instruction/data memories from a word stream, then runs the core to its last PC
module mips_boot_ctrl
    import mips_boot_pkg::*;
#(
    parameter int IMEM_BYTES     = 1024,
    parameter int DMEM_BYTES     = 1024,
    parameter int DRAIN_CYCLES   = 1,
    parameter int MAX_RUN_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        with_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [7:0]  im_wdata,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [7:0]  dm_wdata,
    output logic        cpu_run,
    input  logic [31:0] pc,
    output logic [31:0] end_pc,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        timeout
);
    localparam int RW = $clog2(MAX_RUN_CYCLES) + 1;
    localparam int DW = $clog2(DRAIN_CYCLES) + 1;
    state_t      state_q, state_d;
    logic        with_data_q, with_data_d;
    logic [31:0] addr_q, addr_d, end_pc_q, end_pc_d, seg_bytes;
    logic [RW-1:0] run_cnt_q, run_cnt_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic        im_we_q, im_we_d, dm_we_q, dm_we_d;
    logic [31:0] im_addr_q, im_addr_d, dm_addr_q, dm_addr_d;
    logic [7:0]  im_wdata_q, im_wdata_d, dm_wdata_q, dm_wdata_d;
    logic        load, ovf, hs, ser_valid, ser_ready, seg_end;
    logic        ser_wr, ser_done, ser_last;
    logic [31:0] ser_addr, ser_base;
    logic [7:0]  ser_data;
    mips_word_serializer u_ser (
        .clk(clk), .reset(reset),
        .in_valid(ser_valid), .in_ready(ser_ready),
        .in_word(s_data), .in_base(addr_q), .in_last(s_last),
        .wr_en_d(ser_wr), .wr_addr_d(ser_addr), .wr_data_d(ser_data),
        .word_done(ser_done), .cur_last(ser_last), .cur_base(ser_base)
    );
    always_comb begin
        load        = state_q == S_LOAD_I || state_q == S_LOAD_D;
        seg_bytes   = state_q == S_LOAD_I ? 32'(IMEM_BYTES) : 32'(DMEM_BYTES);
        ovf         = addr_q + 32'(BYTES_PER_WORD) > seg_bytes;
        s_ready     = load && ser_ready;
        hs          = s_valid && s_ready;
        ser_valid   = hs && !ovf;
        seg_end     = load && ser_done && ser_last;
        state_d     = state_q;
        with_data_d = with_data_q;
        addr_d      = addr_q;
        end_pc_d    = end_pc_q;
        run_cnt_d   = run_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR, S_TIMEOUT: if (start) begin
                state_d     = S_LOAD_I;
                with_data_d = with_data;
                addr_d      = '0;
                run_cnt_d   = '0;
                drain_cnt_d = '0;
            end
            S_LOAD_I, S_LOAD_D: if (hs && ovf) begin
                state_d = S_ERROR;
            end else if (hs) begin
                addr_d = addr_q + 32'(BYTES_PER_WORD);
            end else if (seg_end) begin
                addr_d   = '0;
                end_pc_d = state_q == S_LOAD_I ? ser_base : end_pc_q;
                state_d  = (state_q == S_LOAD_I && with_data_q) ? S_LOAD_D : S_RUN;
            end
            S_RUN: begin
                run_cnt_d = run_cnt_q + 1'b1;
                state_d   = pc == end_pc_q ? S_DRAIN
                          : run_cnt_q == RW'(MAX_RUN_CYCLES - 1) ? S_TIMEOUT : S_RUN;
            end
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                state_d     = drain_cnt_q == DW'(DRAIN_CYCLES - 1) ? S_DONE : S_DRAIN;
            end
        endcase
        // byte writes are steered by the segment active when they are issued
        im_we_d    = ser_wr && state_q == S_LOAD_I;
        im_addr_d  = im_we_d ? ser_addr : im_addr_q;
        im_wdata_d = im_we_d ? ser_data : im_wdata_q;
        dm_we_d    = ser_wr && state_q == S_LOAD_D;
        dm_addr_d  = dm_we_d ? ser_addr : dm_addr_q;
        dm_wdata_d = dm_we_d ? ser_data : dm_wdata_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            with_data_q <= 1'b0;
            addr_q      <= '0;
            end_pc_q    <= '0;
            run_cnt_q   <= '0;
            drain_cnt_q <= '0;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= '0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            with_data_q <= with_data_d;
            addr_q      <= addr_d;
            end_pc_q    <= end_pc_d;
            run_cnt_q   <= run_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            im_we_q     <= im_we_d;
            im_addr_q   <= im_addr_d;
            im_wdata_q  <= im_wdata_d;
            dm_we_q     <= dm_we_d;
            dm_addr_q   <= dm_addr_d;
            dm_wdata_q  <= dm_wdata_d;
        end
    end
    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_wdata = dm_wdata_q;
    assign end_pc   = end_pc_q;
    assign cpu_run  = state_q == S_RUN || state_q == S_DRAIN;
    assign busy     = load || cpu_run;
    assign done     = state_q == S_DONE;
    assign err      = state_q == S_ERROR;
    assign timeout  = state_q == S_TIMEOUT;
endmodule

// File: tb/tb_mips_boot_ctrl.sv
// tb_mips_boot_ctrl: directed checks of load, run, overflow, timeout and reset behaviour
module tb_mips_boot_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1, start = 1'b0, with_data = 1'b0, s_valid = 1'b0, s_last = 1'b0;
    logic [31:0] s_data = '0, pc = 32'h100;
    logic s_ready, im_we, dm_we, cpu_run, busy, done, err, timeout;
    logic [31:0] im_addr, dm_addr, end_pc;
    logic [7:0] im_wdata, dm_wdata;
    int total = 0, bad = 0;
    logic [7:0] im_mem [64];
    logic [7:0] dm_mem [64];
    int im_cnt = 0, dm_cnt = 0, im_hi = 0;
    mips_boot_ctrl #(.IMEM_BYTES(16), .DMEM_BYTES(8), .DRAIN_CYCLES(1), .MAX_RUN_CYCLES(20)) dut (
        .clk(clk), .reset(reset), .start(start), .with_data(with_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .cpu_run(cpu_run), .pc(pc), .end_pc(end_pc),
        .busy(busy), .done(done), .err(err), .timeout(timeout)
    );
    always @(posedge clk) begin
        if (im_we) begin
            im_mem[im_addr[5:0]] <= im_wdata;
            im_cnt <= im_cnt + 1;
            if (im_addr >= 32'd16) im_hi <= im_hi + 1;
        end
        if (dm_we) begin
            dm_mem[dm_addr[5:0]] <= dm_wdata;
            dm_cnt <= dm_cnt + 1;
        end
    end
    function automatic logic [31:0] imw(input int a);
        return {im_mem[a+3], im_mem[a+2], im_mem[a+1], im_mem[a]};
    endfunction
    function automatic logic [31:0] dmw(input int a);
        return {dm_mem[a+3], dm_mem[a+2], dm_mem[a+1], dm_mem[a]};
    endfunction
    function automatic logic [119:0] all_out();
        return {s_ready, im_we, im_addr, im_wdata, dm_we, dm_addr, dm_wdata,
                cpu_run, end_pc, busy, done, err, timeout};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic begin_session(input logic wd);
        start = 1'b1;
        with_data = wd;
        tick();
        start = 1'b0;
    endtask
    task automatic send(input logic [31:0] w, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data = w;
        s_last = l;
        while (!s_ready && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_wait: s_ready=%b after %0d cycles, required 1", s_ready, n);
        end
        tick();
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask
    task automatic wait_run();
        int n;
        n = 0;
        while (!cpu_run && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (cpu_run !== 1'b1) begin
            bad++;
            $display("FAIL wait_run: cpu_run=%b after %0d cycles, required 1", cpu_run, n);
        end
    endtask
    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++;
        if (all_out() !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h, required 0", all_out());
        end
    endtask
    task automatic test_instr_only();
        int c0;
        c0 = im_cnt;
        begin_session(1'b0);
        total++;
        if ({busy, s_ready} !== 2'b11) begin
            bad++;
            $display("FAIL load_i_entry: busy,s_ready=%b, required 11", {busy, s_ready});
        end
        send(32'h20080005, 1'b0);
        send(32'h20090007, 1'b0);
        send(32'h01095020, 1'b1);
        tick(); tick(); tick();
        total++;
        if ({im_we, im_addr, im_wdata, cpu_run} !== {1'b1, 32'd11, 8'h01, 1'b0}) begin
            bad++;
            $display("FAIL last_byte: we=%b addr=%0d data=%h run=%b, required 1 11 01 0",
                     im_we, im_addr, im_wdata, cpu_run);
        end
        tick();
        total++;
        if ({cpu_run, busy, end_pc} !== {1'b1, 1'b1, 32'd8}) begin
            bad++;
            $display("FAIL run_entry: run=%b busy=%b end_pc=%0d, required 1 1 8", cpu_run, busy, end_pc);
        end
        total++;
        if ({imw(0), imw(4), imw(8)} !== {32'h20080005, 32'h20090007, 32'h01095020} || im_cnt - c0 != 12) begin
            bad++;
            $display("FAIL imem_words: %h %h %h writes=%0d, required 20080005 20090007 01095020 12",
                     imw(0), imw(4), imw(8), im_cnt - c0);
        end
        pc = 32'd0; tick();
        pc = 32'd4; tick();
        pc = 32'd8; tick();
        total++;
        if ({cpu_run, done} !== 2'b10) begin
            bad++;
            $display("FAIL drain: run,done=%b, required 10", {cpu_run, done});
        end
        tick();
        total++;
        if ({cpu_run, done, busy} !== 3'b010) begin
            bad++;
            $display("FAIL done: run,done,busy=%b, required 010", {cpu_run, done, busy});
        end
        pc = 32'h100;
    endtask
    task automatic test_data_segment();
        int c0;
        c0 = dm_cnt;
        begin_session(1'b1);
        send(32'h3C010000, 1'b1);
        send(32'h0000000A, 1'b0);
        send(32'hFFFFFFFF, 1'b1);
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({dm_we, cpu_run, dm_addr, dm_wdata} !== {1'b1, 1'b0, 32'(4 + k), 8'hFF}) begin
                bad++;
                $display("FAIL dmem_tail_%0d: we=%b run=%b addr=%0d data=%h, required 1 0 %0d ff",
                         k, dm_we, cpu_run, dm_addr, dm_wdata, 4 + k);
            end
            tick();
        end
        total++;
        if ({cpu_run, end_pc} !== {1'b1, 32'd0}) begin
            bad++;
            $display("FAIL data_run_entry: run=%b end_pc=%0d, required 1 0", cpu_run, end_pc);
        end
        total++;
        if ({dmw(0), dmw(4), imw(0)} !== {32'h0000000A, 32'hFFFFFFFF, 32'h3C010000} || dm_cnt - c0 != 8) begin
            bad++;
            $display("FAIL dmem_words: %h %h imem0=%h writes=%0d, required 0000000a ffffffff 3c010000 8",
                     dmw(0), dmw(4), imw(0), dm_cnt - c0);
        end
        pc = 32'd0;
        tick();
        tick();
        total++;
        if ({done, cpu_run} !== 2'b10) begin
            bad++;
            $display("FAIL data_done: done,run=%b, required 10", {done, cpu_run});
        end
        pc = 32'h100;
    endtask
    task automatic test_back_to_back();
        logic [31:0] w [4];
        logic [19:0] rdy, we;
        logic hs;
        int i;
        w = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
        begin_session(1'b0);
        i = 0;
        s_valid = 1'b1;
        s_data = w[0];
        s_last = 1'b0;
        for (int c = 0; c < 20; c++) begin
            rdy[c] = s_ready;
            we[c] = im_we;
            hs = s_valid && s_ready;
            tick();
            if (hs) begin
                i++;
                if (i == 4) s_valid = 1'b0;
                else begin
                    s_data = w[i];
                    s_last = i == 3;
                end
            end
        end
        s_last = 1'b0;
        total++;
        if (rdy !== 20'h01111) begin
            bad++;
            $display("FAIL b2b_ready: pattern=%h, required 01111", rdy);
        end
        total++;
        if (we !== 20'h1FFFE) begin
            bad++;
            $display("FAIL b2b_im_we: pattern=%h, required 1fffe", we);
        end
        total++;
        if ({imw(0), imw(4), imw(8), imw(12), end_pc, cpu_run} !== {w[0], w[1], w[2], w[3], 32'd12, 1'b1}) begin
            bad++;
            $display("FAIL b2b_words: %h %h %h %h end_pc=%0d run=%b, required %h %h %h %h 12 1",
                     imw(0), imw(4), imw(8), imw(12), end_pc, cpu_run, w[0], w[1], w[2], w[3]);
        end
        pc = 32'd12;
        tick();
        tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done: done=%b, required 1", done);
        end
        pc = 32'h100;
    endtask
    task automatic test_gapped();
        logic [31:0] w [4];
        int c0;
        w = '{32'hCAFE0001, 32'hBEEF0002, 32'h12345678, 32'h0BADF00D};
        c0 = im_cnt;
        begin_session(1'b0);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 5)) tick();
            send(w[i], i == 3);
        end
        wait_run();
        total++;
        if ({imw(0), imw(4), imw(8), imw(12)} !== {w[0], w[1], w[2], w[3]} || im_cnt - c0 != 16) begin
            bad++;
            $display("FAIL gapped_words: %h %h %h %h writes=%0d, required %h %h %h %h 16",
                     imw(0), imw(4), imw(8), imw(12), im_cnt - c0, w[0], w[1], w[2], w[3]);
        end
        pc = 32'd12;
        tick();
        tick();
        pc = 32'h100;
    endtask
    task automatic test_timeout();
        int n;
        begin_session(1'b0);
        pc = 32'd4;
        send(32'h00000000, 1'b1);
        wait_run();
        n = 0;
        while (cpu_run && n < 100) begin
            n++;
            tick();
        end
        total++;
        if (n != 20) begin
            bad++;
            $display("FAIL timeout_cycles: run cycles=%0d, required 20", n);
        end
        total++;
        if ({timeout, done, cpu_run, busy} !== 4'b1000) begin
            bad++;
            $display("FAIL timeout_flags: timeout,done,run,busy=%b, required 1000", {timeout, done, cpu_run, busy});
        end
        pc = 32'h100;
    endtask
    task automatic test_overflow();
        int c0, h0;
        c0 = im_cnt;
        h0 = im_hi;
        begin_session(1'b0);
        total++;
        if ({timeout, busy} !== 2'b01) begin
            bad++;
            $display("FAIL restart_from_timeout: timeout,busy=%b, required 01", {timeout, busy});
        end
        for (int i = 0; i < 5; i++) send(32'hA0000000 + 32'(i), 1'b0);
        total++;
        if ({err, s_ready, busy, im_we} !== 4'b1000) begin
            bad++;
            $display("FAIL overflow_flags: err,s_ready,busy,im_we=%b, required 1000", {err, s_ready, busy, im_we});
        end
        tick(); tick(); tick();
        total++;
        if (err !== 1'b1 || im_hi != h0 || im_cnt - c0 != 16) begin
            bad++;
            $display("FAIL overflow_writes: err=%b high writes=%0d total writes=%0d, required 1 0 16",
                     err, im_hi - h0, im_cnt - c0);
        end
        begin_session(1'b0);
        total++;
        if ({err, busy, s_ready} !== 3'b011) begin
            bad++;
            $display("FAIL err_clear: err,busy,s_ready=%b, required 011", {err, busy, s_ready});
        end
    endtask
    task automatic test_reset_mid();
        send(32'hA1A2A3A4, 1'b0);
        send(32'hB1B2B3B4, 1'b0);
        tick();
        total++;
        if ({im_we, im_addr, im_wdata} !== {1'b1, 32'd5, 8'hB3}) begin
            bad++;
            $display("FAIL mid_byte1: we=%b addr=%0d data=%h, required 1 5 b3", im_we, im_addr, im_wdata);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (all_out() !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %h, required 0", all_out());
        end
        begin_session(1'b0);
        send(32'hC1C2C3C4, 1'b1);
        total++;
        if ({im_we, im_addr, im_wdata} !== {1'b1, 32'd0, 8'hC4}) begin
            bad++;
            $display("FAIL reload_addr0: we=%b addr=%0d data=%h, required 1 0 c4", im_we, im_addr, im_wdata);
        end
    endtask
    initial begin
        test_reset();
        test_instr_only();
        test_data_segment();
        test_back_to_back();
        test_gapped();
        test_timeout();
        test_overflow();
        test_reset_mid();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
